// File: rtl/rat_pkg.sv
// Shared types and sizing helpers for the rational rounding datapath.
package rat_pkg;

  typedef enum logic [1:0] {
    RND_NEAREST = 2'b00,
    RND_FLOOR   = 2'b01,
    RND_CEIL    = 2'b10,
    RND_EVEN    = 2'b11
  } rat_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    RND,
    DONE
  } rat_round_state_e;

  localparam int unsigned RAT_WIDTH = 32;
  localparam int unsigned RAT_CNT_W = $clog2(RAT_WIDTH);

  // Bit-counter width for a given operand width; the counter only ever holds WIDTH-1.
  function automatic int unsigned rat_cnt_width(int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/rat_divstep.sv
// One combinational restoring-division step: shift in the next numerator bit, subtract if it fits.
module rat_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   r,
  input  logic             num_bit,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {r, num_bit};
    diff    = shifted - {2'b00, den};
    q_bit   = (shifted >= {2'b00, den});
    // r < den always holds, so the top bit of shifted is zero and truncation is lossless.
    r_next  = (WIDTH+1)'(q_bit ? diff : shifted);
  end

endmodule

// File: rtl/rat_round_seq.sv
// Bit-serial rational-to-integer rounder with valid/ready handshakes.
// Define RAT_ROUND_HALF_EVEN_EN to enable round-half-to-even for mode 11 (else it acts as mode 00).
module rat_round_seq
  import rat_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic [WIDTH-1:0] out_den,
  output logic             out_inexact,
  output logic             out_div_zero
);

  localparam int unsigned CntW = rat_cnt_width(WIDTH);

  rat_round_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;
  rat_mode_e        mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_num_q, out_num_d;
  logic [WIDTH-1:0] out_den_q, out_den_d;
  logic             out_inexact_q, out_inexact_d;
  logic             out_div_zero_q, out_div_zero_d;

  logic [WIDTH:0]   step_r;
  logic             step_q;

  rat_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .r       (r_q),
    .num_bit (num_q[cnt_q]),
    .den     (den_q),
    .r_next  (step_r),
    .q_bit   (step_q)
  );

  // Exact half-way compare: 2r against den at WIDTH+2 bits.
  logic [WIDTH+1:0] twice_r;
  logic [WIDTH+1:0] den_ext;
  logic             rem_nz;
  logic             half_ge;
  logic             round_up;
  logic [WIDTH-1:0] rounded;
`ifdef RAT_ROUND_HALF_EVEN_EN
  logic             half_gt;
  logic             half_eq;
`endif

  always_comb begin
    twice_r  = {r_q, 1'b0};
    den_ext  = {2'b00, den_q};
    rem_nz   = |r_q;
    half_ge  = (twice_r >= den_ext);
`ifdef RAT_ROUND_HALF_EVEN_EN
    half_gt  = (twice_r > den_ext);
    half_eq  = (twice_r == den_ext);
`endif
    round_up = 1'b0;
    unique case (mode_q)
      RND_NEAREST: round_up = half_ge;
      RND_FLOOR:   round_up = 1'b0;
      RND_CEIL:    round_up = rem_nz;
`ifdef RAT_ROUND_HALF_EVEN_EN
      RND_EVEN:    round_up = half_gt | (half_eq & q_q[0]);
`else
      RND_EVEN:    round_up = half_ge;
`endif
      default:     round_up = 1'b0;
    endcase
    // Cannot overflow: den >= 2 keeps q below 2^(WIDTH-1), den == 1 leaves r == 0.
    rounded = q_q + WIDTH'(round_up);
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    num_d          = num_q;
    den_d          = den_q;
    mode_d         = mode_q;
    q_d            = q_q;
    r_d            = r_q;
    out_num_d      = out_num_q;
    out_den_d      = out_den_q;
    out_inexact_d  = out_inexact_q;
    out_div_zero_d = out_div_zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          num_d  = in_num;
          den_d  = in_den;
          mode_d = rat_mode_e'(in_mode);
          if (in_den == '0) begin
            out_num_d      = '0;
            out_den_d      = '0;
            out_inexact_d  = 1'b0;
            out_div_zero_d = 1'b1;
            state_d        = DONE;
          end else begin
            q_d     = '0;
            r_d     = '0;
            cnt_d   = CntW'(WIDTH - 1);
            state_d = DIV;
          end
        end
      end
      DIV: begin
        r_d        = step_r;
        q_d[cnt_q] = step_q;
        if (cnt_q == '0) begin
          state_d = RND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RND: begin
        out_num_d      = rounded;
        out_den_d      = WIDTH'(1);
        out_inexact_d  = rem_nz;
        out_div_zero_d = 1'b0;
        state_d        = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_num_d      = '0;
          out_den_d      = '0;
          out_inexact_d  = 1'b0;
          out_div_zero_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered from the next state, keeping out_ready off any comb path.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      num_q          <= '0;
      den_q          <= '0;
      mode_q         <= RND_NEAREST;
      q_q            <= '0;
      r_q            <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_num_q      <= '0;
      out_den_q      <= '0;
      out_inexact_q  <= 1'b0;
      out_div_zero_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      num_q          <= num_d;
      den_q          <= den_d;
      mode_q         <= mode_d;
      q_q            <= q_d;
      r_q            <= r_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_num_q      <= out_num_d;
      out_den_q      <= out_den_d;
      out_inexact_q  <= out_inexact_d;
      out_div_zero_q <= out_div_zero_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_num      = out_num_q;
  assign out_den      = out_den_q;
  assign out_inexact  = out_inexact_q;
  assign out_div_zero = out_div_zero_q;

endmodule

// File: tb/tb_rat_round_seq.sv
// Directed and random checks of rat_round_seq at WIDTH=32.
module tb_rat_round_seq;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_num;
  logic [WIDTH-1:0] in_den;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_num;
  logic [WIDTH-1:0] out_den;
  logic             out_inexact;
  logic             out_div_zero;

  int errors = 0;
  int checks = 0;

  // Results captured by run_op.
  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_den;
  logic             r_inx;
  logic             r_dz;
  int               r_lat;
  bit               r_to;

`ifdef RAT_ROUND_HALF_EVEN_EN
  localparam logic [WIDTH-1:0] Exp5Div2Even = 32'd2;
`else
  localparam logic [WIDTH-1:0] Exp5Div2Even = 32'd3;
`endif

  rat_round_seq #(
    .WIDTH (WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_num       (in_num),
    .in_den       (in_den),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_num      (out_num),
    .out_den      (out_den),
    .out_inexact  (out_inexact),
    .out_div_zero (out_div_zero)
  );

  always #5 clk = ~clk;

  function automatic void ref_round(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d,
                                    input logic [1:0] m, output logic [WIDTH-1:0] res,
                                    output logic inx, output logic dz);
    longint unsigned q, r, tr, dd;
    bit u;
    if (d == 0) begin
      res = '0; inx = 1'b0; dz = 1'b1;
      return;
    end
    dd = longint'(d);
    q  = longint'(n) / dd;
    r  = longint'(n) % dd;
    tr = 2 * r;
    case (m)
      2'd0: u = (tr >= dd);
      2'd1: u = 1'b0;
      2'd2: u = (r != 0);
`ifdef RAT_ROUND_HALF_EVEN_EN
      default: u = (tr > dd) || ((tr == dd) && q[0]);
`else
      default: u = (tr >= dd);
`endif
    endcase
    res = WIDTH'(q + longint'(u));
    inx = (r != 0);
    dz  = 1'b0;
  endfunction

  // Issue one operation; called and returns #1 after a rising edge.
  task automatic run_op(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d,
                        input logic [1:0] m, input bit release_out);
    int w;
    r_to = 1'b0;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1; in_num = n; in_den = d; in_mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r_lat = 0;
    while (!out_valid && r_lat < 100) begin
      @(posedge clk); #1; r_lat++;
    end
    if (!out_valid || w >= 50) r_to = 1'b1;
    r_num = out_num; r_den = out_den; r_inx = out_inexact; r_dz = out_div_zero;
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_num = '0; in_den = '0; in_mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_num !== '0 || out_den !== '0 ||
        out_inexact !== 1'b0 || out_div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b num=%h den=%h inx=%b dz=%b want 0 0 0 0 0 0",
               in_ready, out_valid, out_num, out_den, out_inexact, out_div_zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic [1:0]       mode;
    logic [WIDTH-1:0] exp;
    logic             inx;
  } vec_t;

  task automatic test_directed();
    vec_t v [10];
    v[0] = '{32'd7, 32'd2, 2'd0, 32'd4, 1'b1};
    v[1] = '{32'd7, 32'd2, 2'd1, 32'd3, 1'b1};
    v[2] = '{32'd1, 32'd3, 2'd0, 32'd0, 1'b1};
    v[3] = '{32'd2, 32'd3, 2'd0, 32'd1, 1'b1};
    v[4] = '{32'd5, 32'd2, 2'd3, Exp5Div2Even, 1'b1};
    v[5] = '{32'd7, 32'd2, 2'd3, 32'd4, 1'b1};
    v[6] = '{32'd10, 32'd3, 2'd2, 32'd4, 1'b1};
    v[7] = '{32'd9, 32'd3, 2'd2, 32'd3, 1'b0};
    v[8] = '{32'hFFFF_FFFF, 32'd1, 2'd0, 32'hFFFF_FFFF, 1'b0};
    v[9] = '{32'd7, 32'd2, 2'd2, 32'd4, 1'b1};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].num, v[i].den, v[i].mode, 1'b1);
      checks++;
      if (r_to || r_num !== v[i].exp || r_inx !== v[i].inx || r_den !== 32'd1 ||
          r_dz !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d] %0d/%0d m%0d: to=%b num=%0d inx=%b den=%0d dz=%b want %0d %b 1 0",
                 i, v[i].num, v[i].den, v[i].mode, r_to, r_num, r_inx, r_den, r_dz,
                 v[i].exp, v[i].inx);
      end
      if (i == 0) begin
        // Edges after the accept edge until out_valid is seen: out_valid lives in cycle WIDTH+2.
        checks++;
        if (r_lat != WIDTH + 1) begin
          errors++;
          $display("FAIL latency: got %0d edges want %0d", r_lat, WIDTH + 1);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    run_op(32'd7, 32'd0, 2'd0, 1'b1);
    checks++;
    if (r_to || r_lat != 0) begin
      errors++;
      $display("FAIL div_zero_latency: got %0d edges (to=%b) want 0", r_lat, r_to);
    end
    checks++;
    if (r_dz !== 1'b1 || r_den !== '0 || r_num !== '0 || r_inx !== 1'b0) begin
      errors++;
      $display("FAIL div_zero_flags: dz=%b den=%0d num=%0d inx=%b want 1 0 0 0",
               r_dz, r_den, r_num, r_inx);
    end
  endtask

  task automatic test_hold();
    run_op(32'd7, 32'd2, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      // Operands offered while busy must be ignored.
      in_valid = 1'b1; in_num = 32'd1; in_den = 32'd1; in_mode = 2'd1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_num !== 32'd4 || out_den !== 32'd1 ||
          out_inexact !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: vld=%b num=%0d den=%0d inx=%b rdy=%b want 1 4 1 1 0",
                 i, out_valid, out_num, out_den, out_inexact, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_num !== '0 || out_den !== '0 || out_inexact !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: vld=%b num=%0d den=%0d inx=%b rdy=%b want 0 0 0 0 1",
               out_valid, out_num, out_den, out_inexact, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int edges, vld_cycles;
    logic [WIDTH-1:0] seen;
    out_ready = 1'b1;
    in_valid = 1'b1; in_num = 32'd10; in_den = 32'd3; in_mode = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0; vld_cycles = 0; seen = '0;
    while (!in_ready && edges < 100) begin
      @(posedge clk); #1; edges++;
      if (out_valid) begin
        vld_cycles++; seen = out_num;
      end
    end
    checks++;
    if (edges != WIDTH + 2 || vld_cycles != 1 || seen !== 32'd3) begin
      errors++;
      $display("FAIL back_to_back_first: edges=%0d vld_cycles=%0d num=%0d want %0d 1 3",
               edges, vld_cycles, seen, WIDTH + 2);
    end
    out_ready = 1'b0;
    run_op(32'd9, 32'd3, 2'd2, 1'b1);
    checks++;
    if (r_to || r_num !== 32'd3 || r_inx !== 1'b0 || r_lat != WIDTH + 1) begin
      errors++;
      $display("FAIL back_to_back_second: to=%b num=%0d inx=%b lat=%0d want 3 0 %0d",
               r_to, r_num, r_inx, r_lat, WIDTH + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit rose;
    in_valid = 1'b1; in_num = 32'd7; in_den = 32'd2; in_mode = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_during: vld=%b rdy=%b want 0 0", out_valid, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b want 1", in_ready);
    end
    rose = 1'b0;
    for (int i = 0; i < WIDTH + 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1'b1;
    end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL reset_mid_no_output: out_valid rose=1 want 0");
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] n, d, e_num;
    logic [1:0] m;
    logic e_inx, e_dz;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0: begin n = $urandom; d = $urandom_range(0, 5); end
        1: begin n = $urandom_range(0, 40); d = $urandom_range(1, 12); end
        2: begin n = $urandom; d = $urandom >> $urandom_range(0, 31); end
        default: begin n = $urandom; d = $urandom; end
      endcase
      m = 2'($urandom_range(0, 3));
      ref_round(n, d, m, e_num, e_inx, e_dz);
      run_op(n, d, m, 1'b1);
      checks++;
      if (r_to || r_num !== e_num || r_inx !== e_inx || r_dz !== e_dz ||
          r_den !== (e_dz ? 32'd0 : 32'd1)) begin
        errors++;
        $display("FAIL random[%0d] %h/%h m%0d: to=%b num=%h inx=%b dz=%b den=%0d want %h %b %b",
                 i, n, d, m, r_to, r_num, r_inx, r_dz, r_den, e_num, e_inx, e_dz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rat_round_seq.md
# rat_round_seq

Sequential, parametrised rational-to-integer rounding unit for the rational arithmetic (rat) datapath. It accepts an unsigned numerator/denominator pair over a valid/ready handshake and computes the quotient with a bit-serial restoring divider. It then applies one of several rounding modes and returns the integer result with status flags. It replaces the fixed single-mode rounder, adding selectable modes, exact half-way comparison, divide-by-zero handling and back-pressure.

## Interface
- WIDTH, 32: operand and result width in bits, ≥ 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  unit can accept operands.
- in_num  in  WIDTH  numerator, unsigned.
- in_den  in  WIDTH  denominator, unsigned.
- in_mode  in  2  rounding mode: 00 nearest/half-up, 01 floor, 10 ceil, 11 nearest/half-even.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_num  out  WIDTH  rounded quotient.
- out_den  out  WIDTH  1 on success, 0 on divide-by-zero.
- out_inexact  out  1  remainder was non-zero.
- out_div_zero  out  1  in_den was 0.

## Operation
- FSM states: IDLE → DIV → RND → DONE → IDLE.
- IDLE: in_ready=1. When in_valid, latch num, den and mode.
  - den==0: go to DONE with out_num=0, out_den=0, out_div_zero=1, out_inexact=0.
  - Otherwise: clear q and r, load the bit counter with WIDTH-1, go to DIV.
- DIV: perform one restoring step per cycle, MSB first.
  - r' = {r, num[cnt]}.
  - If r' ≥ den: r = r' − den and q[cnt]=1. Otherwise r = r' and q[cnt]=0.
  - r is WIDTH+1 bits wide. Leave DIV after cnt==0.
- RND: compute the round-up bit u from q, r and den. The half-way compare is exact, using 2r against den at WIDTH+2 bits, never r ≥ den/2. Per mode:
  - 00: u = (2r ≥ den).
  - 01: u = 0.
  - 10: u = (r ≠ 0).
  - 11: u = (2r > den) | ((2r == den) & q[0]).
- RND result: out_num = q + u, out_den = 1, out_inexact = (r ≠ 0). Go to DONE.
- DONE: hold out_valid=1 and all outputs stable until out_ready. On the handshake cycle go to IDLE.
- Overflow cannot occur. With den ≥ 2, q < 2^(WIDTH-1). With den==1, r==0, so u=0.
- in_ready is 0 outside IDLE. in_valid asserted outside IDLE is ignored, not queued.

## Timing
- Reset values: in_ready=0 during the rst cycle, 1 in the first cycle after. out_valid=0, out_num=0, out_den=0, out_inexact=0, out_div_zero=0. FSM=IDLE, counter=0.
- Accept edge = cycle 0. DIV occupies cycles 1..WIDTH. RND is cycle WIDTH+1. out_valid rises at cycle WIDTH+2 (34 for WIDTH=32).
- Divide-by-zero: out_valid at cycle 1.
- Throughput: one result per WIDTH+3 cycles with out_ready held high. The next accept is possible in the cycle after the output handshake.
- out_valid and in_ready are registered outputs, with no combinational path from out_ready.
- rst mid-operation, in any state, aborts the operation and returns to reset values the next cycle. No partial result is emitted.
- Output flags are valid only while out_valid=1 and are cleared on handshake.

## Configuration
- RAT_ROUND_HALF_EVEN_EN defined: mode 11 implements round-half-to-even as specified.
- RAT_ROUND_HALF_EVEN_EN undefined: mode 11 behaves exactly as mode 00, and the q[0] tie-break logic is not synthesised.

## Structure
- Package rat_pkg:
  - rat_mode_e enum: RND_NEAREST, RND_FLOOR, RND_CEIL, RND_EVEN.
  - rat_round_state_e enum: IDLE, DIV, RND, DONE.
  - Localparam for counter width $clog2(WIDTH).
- Sub-module rat_divstep: combinational single restoring-division step, parameter WIDTH.
  - Inputs: r, next numerator bit, den.
  - Outputs: r_next, q_bit.
  - Instantiated once inside rat_round_seq.

## Test plan
- 7/2, mode 00 → out_num=4, out_inexact=1. Same operands, mode 01 → 3.
- 1/3, mode 00 → 0. Exact compare, 2·1 < 3. 2/3, mode 00 → 1.
- 5/2, mode 11 → 2. 7/2, mode 11 → 4. With RAT_ROUND_HALF_EVEN_EN undefined, 5/2 mode 11 → 3.
- 10/3, mode 10 → 4. 9/3, mode 10 → 3, out_inexact=0. 0xFFFFFFFF/1, mode 00 → 0xFFFFFFFF.
- 7/0 → out_valid at cycle 1, out_div_zero=1, out_den=0, out_num=0.
- Hold out_ready=0 for 10 cycles after out_valid → outputs stable and in_ready=0. Assert rst at DIV cycle 5 → out_valid never rises, in_ready=1 one cycle after rst deasserts. 1000 random pairs with random modes match the reference model.
